// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the write-back path: datapath widths, the
// buffered write-back entry, the buffer occupancy encoding and a helper
// that decides whether a request really updates the register file.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  // One pending register-file write: destination index and selected data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // Occupancy of the two-entry write-back buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  // A request writes the register file only when RegWrite is set and the
  // destination is not the hard-wired zero register.
  function automatic logic is_live_write(input logic                  reg_write,
                                         input logic [REG_ADDR_W-1:0] rd);
    return reg_write & (rd != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry FIFO holding pending register-file writes. Occupancy is kept as
// an EMPTY/ONE/TWO state machine; full/empty are registered alongside it so
// the consumer sees glitch-free flags. The head entry reads as zero while
// empty so downstream outputs are clean in reset and idle.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head_entry,
  output logic      full,
  output logic      empty
);

  occ_state_t state_r;
  wb_entry_t  entry_r [DEPTH];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic       full_r;
  logic       empty_r;
  logic       push_s;
  logic       pop_s;

  // Never overrun a full buffer or underrun an empty one.
  assign push_s = push & ~full_r;
  assign pop_s  = pop & ~empty_r;

  // Occupancy FSM together with storage, pointers and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= EMPTY;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        entry_r[wr_ptr_r] <= push_entry;
        wr_ptr_r          <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            state_r <= ONE;
            empty_r <= 1'b0;
          end
        end
        ONE: begin
          if (push_s && !pop_s) begin
            state_r <= TWO;
            full_r  <= 1'b1;
          end else if (!push_s && pop_s) begin
            state_r <= EMPTY;
            empty_r <= 1'b1;
          end
        end
        TWO: begin
          if (pop_s) begin
            state_r <= ONE;
            full_r  <= 1'b0;
          end
        end
        default: begin
          state_r  <= EMPTY;
          full_r   <= 1'b0;
          empty_r  <= 1'b1;
          wr_ptr_r <= 1'b0;
          rd_ptr_r <= 1'b0;
        end
      endcase
    end
  end

  // Present the oldest entry, or zeros when nothing is pending.
  always_comb begin
    head_entry = '0;
    if (empty_r) begin
      head_entry = '0;
    end else begin
      head_entry = entry_r[rd_ptr_r];
    end
  end

  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/register_writeback.sv
// Register write-back stage: selects load or ALU data at acceptance, drops
// requests that do not write the register file, buffers up to two pending
// writes and drains them in order through the register-file write port.
// Optional operand forwarding of the oldest pending write is enabled by
// defining REGISTER_WRITEBACK_FORWARD_EN; otherwise the forward port is 0.
module register_writeback
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [DATA_W-1:0]     in_alu_result,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_ready,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [15:0]           wb_count,
  output logic [15:0]           drop_count
);

  generate
    if (DEPTH != 2) begin : g_bad_depth
      $error("register_writeback: DEPTH must be 2");
    end
    if (NUM_REGS != (1 << REG_ADDR_W)) begin : g_bad_regs
      $error("register_writeback: NUM_REGS must match REG_ADDR_W");
    end
  endgenerate

  logic      accept_s;
  logic      live_s;
  logic      push_s;
  logic      drop_s;
  logic      pop_s;
  logic      fifo_full_s;
  logic      fifo_empty_s;
  wb_entry_t push_entry_s;
  wb_entry_t head_entry_s;
  logic [15:0] wb_count_r;
  logic [15:0] drop_count_r;

  // Ready is held low during reset and whenever both slots are occupied.
  assign in_ready = ~rst & ~fifo_full_s;
  assign accept_s = in_valid & in_ready;
  assign live_s   = is_live_write(in_reg_write, in_rd);
  assign push_s   = accept_s & live_s;
  assign drop_s   = accept_s & ~live_s;
  assign pop_s    = wr_en & wr_ready;

  // Choose load data or ALU result once, at acceptance.
  always_comb begin
    push_entry_s    = '0;
    push_entry_s.rd = in_rd;
    if (in_mem_to_reg) begin
      push_entry_s.data = in_mem_data;
    end else begin
      push_entry_s.data = in_alu_result;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head_entry (head_entry_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s)
  );

  // Retired-write and dropped-request counters; both wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_count_r   <= 16'd0;
      drop_count_r <= 16'd0;
    end else begin
      if (pop_s) begin
        wb_count_r <= wb_count_r + 16'd1;
      end
      if (drop_s) begin
        drop_count_r <= drop_count_r + 16'd1;
      end
    end
  end

  assign wr_en      = ~fifo_empty_s;
  assign wr_addr    = head_entry_s.rd;
  assign wr_data    = head_entry_s.data;
  assign wb_count   = wb_count_r;
  assign drop_count = drop_count_r;

`ifdef REGISTER_WRITEBACK_FORWARD_EN
  assign fwd_valid = wr_en;
  assign fwd_addr  = wr_addr;
  assign fwd_data  = wr_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = {REG_ADDR_W{1'b0}};
  assign fwd_data  = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback with a scoreboard: each accepted
// live request queues its expected (rd, data); a negedge monitor pops and
// compares on every retiring write.
module tb_register_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [31:0] in_mem_data;
  logic [31:0] in_alu_result;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [15:0] wb_count;
  logic [15:0] drop_count;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  register_writeback #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
    .in_mem_data   (in_mem_data),
    .in_alu_result (in_alu_result),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .fwd_valid     (fwd_valid),
    .fwd_addr      (fwd_addr),
    .fwd_data      (fwd_data),
    .wb_count      (wb_count),
    .drop_count    (drop_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one request, wait (bounded) for acceptance, queue the expectation.
  task automatic send(input logic [4:0] rd, input logic rw, input logic m2r,
                      input logic [31:0] mem, input logic [31:0] alu);
    bit   done = 1'b0;
    exp_t x;
    in_valid      = 1'b1;
    in_rd         = rd;
    in_reg_write  = rw;
    in_mem_to_reg = m2r;
    in_mem_data   = mem;
    in_alu_result = alu;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) begin
        if (rw && rd != 5'd0) begin
          x.a = rd;
          x.d = m2r ? mem : alu;
          sb_q.push_back(x);
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: rd %0d never accepted within 20 cycles", rd);
    end
  endtask

  task automatic chk_fwd(input string name, input logic en, input logic [4:0] a, input logic [31:0] d);
`ifdef REGISTER_WRITEBACK_FORWARD_EN
    chk({name, "_fwd_valid"}, {31'd0, fwd_valid}, {31'd0, en});
    chk({name, "_fwd_addr"}, {27'd0, fwd_addr}, {27'd0, a});
    chk({name, "_fwd_data"}, fwd_data, d);
`else
    chk({name, "_fwd_valid"}, {31'd0, fwd_valid}, {31'd0, en & 1'b0});
    chk({name, "_fwd_addr"}, {27'd0, fwd_addr}, {27'd0, a & 5'd0});
    chk({name, "_fwd_data"}, fwd_data, d & 32'd0);
`endif
  endtask

  // Monitor: every retiring write must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && wr_en && wr_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", wr_addr, wr_data);
      end else begin
        e = sb_q.pop_front();
        chk("mon_wr_addr", {27'd0, wr_addr}, {27'd0, e.a});
        chk("mon_wr_data", wr_data, e.d);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_rd = 5'd0;
    in_reg_write = 1'b0;
    in_mem_to_reg = 1'b0;
    in_mem_data = 32'd0;
    in_alu_result = 32'd0;
    wr_ready = 1'b1;

    // Reset state.
    tick(2);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wb_count", {16'd0, wb_count}, 32'd0);
    chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk_fwd("rst", 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single ALU write.
    send(5'd3, 1'b1, 1'b0, 32'h0, 32'h0000000F);
    chk("single_wr_en", {31'd0, wr_en}, 32'd1);
    chk("single_wr_addr", {27'd0, wr_addr}, 32'd3);
    chk("single_wr_data", wr_data, 32'd15);
    chk("single_wb_before", {16'd0, wb_count}, 32'd0);
    chk_fwd("single", 1'b1, 5'd3, 32'd15);
    tick(1);
    chk("single_wb_count", {16'd0, wb_count}, 32'd1);
    chk("single_idle", {31'd0, wr_en}, 32'd0);

    // Load write selects memory data.
    send(5'd25, 1'b1, 1'b1, 32'hDEADBEEF, 32'h00001234);
    chk("load_wr_addr", {27'd0, wr_addr}, 32'd25);
    chk("load_wr_data", wr_data, 32'hDEADBEEF);
    tick(1);
    chk("load_wb_count", {16'd0, wb_count}, 32'd2);

    // Drops: rd=0, then reg_write=0.
    send(5'd0, 1'b1, 1'b0, 32'h0, 32'h00000055);
    chk("drop_rd0_count", {16'd0, drop_count}, 32'd1);
    chk("drop_rd0_wr_en", {31'd0, wr_en}, 32'd0);
    send(5'd5, 1'b0, 1'b0, 32'h0, 32'h00000066);
    chk("drop_rw0_count", {16'd0, drop_count}, 32'd2);
    chk("drop_rw0_wr_en", {31'd0, wr_en}, 32'd0);
    chk("drop_wb_count", {16'd0, wb_count}, 32'd2);

    // Backpressure: three offered, two accepted, third held off.
    wr_ready = 1'b0;
    send(5'd7, 1'b1, 1'b0, 32'h0, 32'h00000070);
    send(5'd8, 1'b1, 1'b0, 32'h0, 32'h00000080);
    in_valid = 1'b1;
    in_rd = 5'd9;
    in_reg_write = 1'b1;
    in_alu_result = 32'h00000090;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_addr", {27'd0, wr_addr}, 32'd7);
      chk("bp_hold_data", wr_data, 32'h00000070);
      tick(1);
    end
    chk("bp_wb_count", {16'd0, wb_count}, 32'd2);
    in_valid = 1'b0;
    wr_ready = 1'b1;
    send(5'd9, 1'b1, 1'b0, 32'h0, 32'h00000090);
    tick(2);
    chk("bp_wb_after", {16'd0, wb_count}, 32'd5);
    chk("bp_drained", {31'd0, wr_en}, 32'd0);
    chk("bp_queue_empty", sb_q.size(), 32'd0);

    // Back-to-back writes to the same register stay ordered.
    send(5'd4, 1'b1, 1'b0, 32'h0, 32'h00000001);
    send(5'd4, 1'b1, 1'b0, 32'h0, 32'h00000002);
    tick(2);
    chk("same_rd_wb", {16'd0, wb_count}, 32'd7);
    chk("same_rd_queue", sb_q.size(), 32'd0);

    // Reset while two writes are pending.
    wr_ready = 1'b0;
    send(5'd10, 1'b1, 1'b0, 32'h0, 32'h000000A0);
    send(5'd11, 1'b1, 1'b0, 32'h0, 32'h000000B0);
    chk("two_in_ready", {31'd0, in_ready}, 32'd0);
    chk("two_wr_en", {31'd0, wr_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid_rst_wb", {16'd0, wb_count}, 32'd0);
    chk("mid_rst_drop", {16'd0, drop_count}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    sb_q.delete();
    wr_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_rise", {31'd0, in_ready}, 32'd1);
    tick(3);
    chk("mid_rst_no_retire", {16'd0, wb_count}, 32'd0);
    chk("mid_rst_idle", {31'd0, wr_en}, 32'd0);

    // Counter wrap: 65535 writes, then one more.
    for (int i = 0; i < 65535; i++) begin
      send(5'((i % 31) + 1), 1'b1, 1'b0, 32'h0, i);
    end
    tick(2);
    chk("wrap_preload", {16'd0, wb_count}, 32'h0000FFFF);
    send(5'd1, 1'b1, 1'b0, 32'h0, 32'h0000005A);
    tick(2);
    chk("wrap_zero", {16'd0, wb_count}, 32'd0);
    chk("wrap_queue", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
